// File: rtl/fsm_chk_pkg.sv
// Shared types and stimulus vectors for the fsm/top handshake driver and its benches.
// Vectors are packed {a, b, c, d}.
package fsm_chk_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StZero,
    StGoS2,
    StGoS3,
    StWaitFin,
    StRecB,
    StRecD,
    StDone,
    StFail
  } drv_state_t;

  // Target state encoding, shared so benches can model or preload the target.
  typedef enum logic [2:0] {
    TgtInit,
    TgtS0,
    TgtS1,
    TgtS2,
    TgtS3
  } state_t;

  localparam logic [3:0] VEC_ZERO = 4'b0000;
  localparam logic [3:0] VEC_A    = 4'b1000;
  localparam logic [3:0] VEC_B    = 4'b0100;
  localparam logic [3:0] VEC_C    = 4'b0010;
  localparam logic [3:0] VEC_D    = 4'b0001;

  function automatic logic [3:0] state_vec(drv_state_t s);
    case (s)
      StGoS2:            return VEC_C;
      StGoS3, StWaitFin: return VEC_A;
      StRecB:            return VEC_B;
      StRecD:            return VEC_D;
      default:           return VEC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/fsm_seq_driver_if.sv
// Handshake bundle between the sequence driver (master) and the target/harness side (slave).
interface fsm_seq_driver_if;
  logic       start;
  logic       finished;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] retry_cnt;

  modport master (
    input  start, finished,
    output a, b, c, d, busy, done, err, retry_cnt
  );

  modport slave (
    output start, finished,
    input  a, b, c, d, busy, done, err, retry_cnt
  );
endinterface

// File: rtl/fsm_seq_driver_step_timer.sv
// Loadable down-counter with a zero flag; holds at zero once expired.
module step_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/fsm_seq_driver.sv
// Walks the target INIT->S0->S2->S3, waits for finished under a watchdog, and
// recovers through S1 (b then d) with a bounded number of retries.
module fsm_seq_driver
  import fsm_chk_pkg::*;
#(
  parameter int unsigned STEP_CYC  = 2,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm_seq_driver_if.master     bus
);

  drv_state_t state_q, state_d;
  logic [3:0] vec_q;
  logic       busy_q, done_q, err_q;
  logic [3:0] rc_q, rc_d;
  logic       state_chg;
  logic       step_zero, tmo_zero;

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StZero;
          rc_d    = 4'd0;
        end
      end
      StZero:  if (step_zero) state_d = StGoS2;
      StGoS2:  if (step_zero) state_d = StGoS3;
      StGoS3: begin
        if (bus.finished)   state_d = StDone;
        else if (step_zero) state_d = StWaitFin;
      end
      StWaitFin: begin
        if (bus.finished) begin
          state_d = StDone;
        end else if (tmo_zero) begin
          state_d = (32'(rc_q) < MAX_RETRY) ? StRecB : StFail;
        end
      end
      StRecB:  if (step_zero) state_d = StRecD;
      StRecD: begin
        if (step_zero) begin
          state_d = StZero;
          rc_d    = (rc_q == 4'd15) ? rc_q : rc_q + 4'd1;
        end
      end
      StDone, StFail: state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  assign state_chg = (state_d != state_q);

  // Reloading on every transition makes each held state last exactly STEP_CYC cycles.
  step_timer #(
    .Width (8)
  ) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_chg),
    .load_val (8'(STEP_CYC - 1)),
    .en       (1'b1),
    .zero     (step_zero)
  );

  step_timer #(
    .Width (16)
  ) u_tmo_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_chg && (state_d == StWaitFin)),
    .load_val (16'(TIMEOUT - 1)),
    .en       (state_q == StWaitFin),
    .zero     (tmo_zero)
  );

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      vec_q   <= VEC_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rc_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= state_vec(state_d);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      err_q   <= (state_d == StFail);
      rc_q    <= rc_d;
    end
  end

  assign bus.a         = vec_q[3];
  assign bus.b         = vec_q[2];
  assign bus.c         = vec_q[1];
  assign bus.d         = vec_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.retry_cnt = rc_q;

endmodule

// File: tb/tb_fsm_seq_driver.sv
// Scoreboard bench: a behavioural target plus a per-cycle expected trace built from the
// driver's rules, compared by an independent monitor on the falling edge.
module tb_fsm_seq_driver;
  import fsm_chk_pkg::*;

  localparam int unsigned STEP = 2;
  localparam int unsigned TMO  = 16;
  localparam int unsigned MAXR = 3;
  localparam int          LAT  = 3 * STEP + 2;

  typedef struct packed {
    logic [3:0] vec;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] rc;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  fsm_seq_driver_if bus ();

  fsm_seq_driver #(
    .STEP_CYC  (STEP),
    .TIMEOUT   (TMO),
    .MAX_RETRY (MAXR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cyc = -1;
  logic [3:0] model_rc = 4'd0;
  rec_t q[$];

  // Behavioural target: registered state, finished registered once more.
  state_t tgt_q = TgtInit;
  logic   fin_q = 1'b0;
  logic   tgt_clr = 1'b0, tgt_preload = 1'b0, force_fin0 = 1'b0;
  logic [3:0] vec;
  assign vec = {bus.a, bus.b, bus.c, bus.d};
  assign bus.finished = force_fin0 ? 1'b0 : fin_q;

  function automatic state_t tgt_next(state_t s, logic [3:0] v);
    case (s)
      TgtInit: return (v == VEC_ZERO) ? TgtS0 : s;
      TgtS0:   return v[1] ? TgtS2 : (v[2] ? TgtS1 : s);
      TgtS2:   return v[3] ? TgtS3 : (v[2] ? TgtS1 : s);
      TgtS3:   return v[2] ? TgtS2 : s;
      TgtS1:   return v[0] ? TgtInit : s;
      default: return TgtInit;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst || tgt_clr) begin
      tgt_q <= TgtInit;
      fin_q <= 1'b0;
    end else if (tgt_preload) begin
      tgt_q <= TgtS3;
      fin_q <= 1'b1;
    end else begin
      tgt_q <= tgt_next(tgt_q, vec);
      fin_q <= (tgt_q == TgtS3);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk(logic [3:0] v, logic bz, logic dn, logic er, logic [3:0] rc);
    rec_t r;
    r.vec = v; r.busy = bz; r.done = dn; r.err = er; r.rc = rc;
    return r;
  endfunction

  task automatic push_n(input logic [3:0] v, input int n, input logic [3:0] rc);
    for (int i = 0; i < n; i++) q.push_back(mk(v, 1'b1, 1'b0, 1'b0, rc));
  endtask

  // kind 0: normal target, 1: finished stuck low, 2: target preloaded to S3.
  task automatic build_trace(input int kind);
    q.push_back(mk(VEC_ZERO, 1'b0, 1'b0, 1'b0, model_rc));
    if (kind != 1) begin
      push_n(VEC_ZERO, STEP, 4'd0);
      push_n(VEC_C, STEP, 4'd0);
      // Fresh target reports S3 two cycles after first seeing a; preloaded one is already there.
      push_n(VEC_A, (kind == 2) ? 1 : 3, 4'd0);
      q.push_back(mk(VEC_ZERO, 1'b1, 1'b1, 1'b0, 4'd0));
      q.push_back(mk(VEC_ZERO, 1'b0, 1'b0, 1'b0, 4'd0));
      model_rc = 4'd0;
    end else begin
      for (int att = 0; att <= int'(MAXR); att++) begin
        push_n(VEC_ZERO, STEP, 4'(att));
        push_n(VEC_C, STEP, 4'(att));
        push_n(VEC_A, STEP + TMO, 4'(att));
        if (att < int'(MAXR)) begin
          push_n(VEC_B, STEP, 4'(att));
          push_n(VEC_D, STEP, 4'(att));
        end
      end
      q.push_back(mk(VEC_ZERO, 1'b1, 1'b0, 1'b1, 4'(MAXR)));
      q.push_back(mk(VEC_ZERO, 1'b0, 1'b0, 1'b0, 4'(MAXR)));
      model_rc = 4'(MAXR);
    end
  endtask

  task automatic run(input int kind, input bit extras, input int rst_at, input int gap);
    int off;
    if (kind == 2) tgt_preload = 1'b1;
    else           tgt_clr = 1'b1;
    force_fin0 = (kind == 1);
    @(posedge clk); #1;
    tgt_preload = 1'b0;
    tgt_clr     = 1'b0;
    repeat ((gap < 0) ? $urandom_range(0, 3) : gap) begin
      @(posedge clk); #1;
    end
    build_trace(kind);
    start_cyc = cyc;
    done_cyc  = -1;
    bus.start = 1'b1;
    off = 0;
    while (q.size() != 0 && off < 3000) begin
      @(posedge clk); #1;
      off++;
      bus.start = extras && (off == 2 || off == 4);
      rst = (off != rst_at);
      if (off == rst_at) begin
        while (q.size() > 1) void'(q.pop_back());
        q.push_back(mk(VEC_ZERO, 1'b0, 1'b0, 1'b0, 4'd0));
        model_rc = 4'd0;
      end
    end
    bus.start = 1'b0;
    rst = 1'b1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL run_bound: %0d expected cycles still pending, required 0", q.size());
      q.delete();
    end
    if (kind == 0 && rst_at < 0) begin
      checks++;
      if (done_cyc - start_cyc != LAT) begin
        errors++;
        $display("FAIL done_latency: got %0d cycles, required %0d", done_cyc - start_cyc, LAT);
      end
    end
  endtask

  // Monitor: invariants every cycle, trace comparison whenever a record is pending.
  always @(negedge clk) begin
    rec_t act, exp;
    checks++;
    if (!$onehot0(vec)) begin
      errors++;
      $display("FAIL onehot0: abcd=%b at cycle %0d, required at most one bit", vec, cyc);
    end
    checks++;
    if (bus.done && bus.err) begin
      errors++;
      $display("FAIL done_err_excl: done=1 err=1 at cycle %0d, required not both", cyc);
    end
    if (bus.done) done_cyc = cyc;
    if (q.size() != 0) begin
      exp = q.pop_front();
      act = mk(vec, bus.busy, bus.done, bus.err, bus.retry_cnt);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL trace @%0d: got abcd=%b busy=%b done=%b err=%b rc=%0d, required abcd=%b busy=%b done=%b err=%b rc=%0d",
                 cyc, act.vec, act.busy, act.done, act.err, act.rc,
                 exp.vec, exp.busy, exp.done, exp.err, exp.rc);
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    @(posedge clk); #1;
    q.push_back(mk(VEC_ZERO, 1'b0, 1'b0, 1'b0, 4'd0));
    @(posedge clk); #1;
    q.push_back(mk(VEC_ZERO, 1'b0, 1'b0, 1'b0, 4'd0));
    rst = 1'b1;

    run(0, 1'b0, -1, 2);                    // plain completion
    run(1, 1'b0, -1, 1);                    // retries exhausted -> err
    run(2, 1'b0, -1, 1);                    // target already in S3
    run(0, 1'b1, -1, 1);                    // start while busy ignored
    run(1, 1'b0, 3 * STEP + 5, 1);          // reset inside WAIT_FIN

    for (int i = 0; i < 24; i++) begin
      int kind, mode, rat;
      kind = $urandom_range(0, 2);
      mode = $urandom_range(0, 3);
      rat  = -1;
      if (mode == 1) begin
        case (kind)
          1:       rat = $urandom_range(1, 95);
          2:       rat = $urandom_range(1, 5);
          default: rat = $urandom_range(1, 7);
        endcase
      end
      run(kind, mode == 0, rat, -1);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
